if_stage: RTL



---
 rtl/rv_pkg.sv | 21 ++
 rtl/if_stage_if.sv | 29 ++
 rtl/if_stage_if_id_reg.sv | 37 +++
 rtl/if_stage.sv | 127 ++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I pipeline types and constants
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PC_plus_4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/response channel
interface if_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with load/bubble/hold
module if_id_reg
  import rv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t id_q, id_d;

  // Load wins over bubble; a bubble keeps PC fields so decode sees stable addresses.
  always_comb begin
    id_d = id_q;
    if (load) begin
      id_d = d;
    end else if (bubble) begin
      id_d.instruction = NOP_INSTR;
      id_d.valid       = 1'b0;
    end
  end

  // Register state, cleared straight to an invalid NOP on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q <= '{instruction: NOP_INSTR, PC: '0, PC_plus_4: '0, valid: 1'b0};
    end else begin
      id_q <= id_d;
    end
  end

  assign q = id_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction fetch stage with one outstanding request
module if_stage
  import rv_pkg::*;
#(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 32,
  parameter logic [31:0]     RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  if_stage_if.master            imem,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PC_plus_4,
  output logic                  if_valid
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  if_id_t                hold_q, hold_d;
  if_id_t                rsp_entry;
  if_id_t                id_data;
  if_id_t                id_q;
  logic                  id_load;
  logic                  id_bubble;
  logic                  handshake;

  assign imem.imem_req_valid = (state_q == FETCH) && !rst;
  assign imem.imem_req_addr  = pc_q;

  // Fetch FSM, PC sequencing and IF/ID control; redirect overrides everything else.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    hold_d     = hold_q;
    id_load    = 1'b0;
    id_data    = hold_q;
    handshake  = (state_q == FETCH) && imem.imem_req_ready;
    rsp_entry  = '{instruction: imem.imem_rsp_data, PC: fetch_pc_q,
                   PC_plus_4: fetch_pc_q + ADDR_WIDTH'(4), valid: 1'b1};

    case (state_q)
      FETCH: begin
        if (handshake) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + ADDR_WIDTH'(4);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (stall) begin
            hold_d  = rsp_entry;
            state_d = HOLD;
          end else begin
            id_load = 1'b1;
            id_data = rsp_entry;
            state_d = FETCH;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          id_load = 1'b1;
          id_data = hold_q;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (imem.imem_rsp_valid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (redirect_valid) begin
      pc_d    = redirect_pc & ~ADDR_WIDTH'(3);
      id_load = 1'b0;
      hold_d  = hold_q;
      if (state_q == FETCH) begin
        state_d = handshake ? DROP : FETCH;
      end else if (state_q == HOLD) begin
        state_d = FETCH;
      end else begin
        state_d = imem.imem_rsp_valid ? FETCH : DROP;
      end
    end

    id_bubble = !id_load && (!stall || redirect_valid);
  end

  // State, PC, in-flight PC and stall hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= ADDR_WIDTH'(RESET_PC);
      fetch_pc_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      hold_q     <= hold_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (id_load),
    .bubble (id_bubble),
    .d      (id_data),
    .q      (id_q)
  );

  assign instruction = id_q.instruction;
  assign PC          = id_q.PC;
  assign PC_plus_4   = id_q.PC_plus_4;
  assign if_valid    = id_q.valid;

endmodule
